// File: rtl/mandel_pkg.sv
// mandel_pkg: shared state encoding, default formats, escape threshold and colour map for mandel_stream_gen.
package mandel_pkg;
  typedef enum logic [1:0] {INIT, ITER, OUT} state_t;
  localparam int DATA_W_DEF = 32;
  localparam int FRAC_BITS_DEF = 24;
  localparam int ITER_W_DEF = 8;
  function automatic logic [127:0] escape_thresh(input int frac_bits);
    return 128'd4 << (2 * frac_bits);
  endfunction
  function automatic logic [23:0] colour(input logic [7:0] n, input logic in_set);
    return in_set ? 24'h0 : {n[4:0], 3'b0, n[5:0], 2'b0, n};
  endfunction
endpackage

// File: rtl/mandel_iter_core.sv
// mandel_iter_core: registered z = z^2 + c step with escape test on the current z.
module mandel_iter_core
  import mandel_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                     clk,
  input  logic                     load,
  input  logic                     step,
  input  logic signed [DATA_W-1:0] z0_re,
  input  logic signed [DATA_W-1:0] z0_im,
  input  logic signed [DATA_W-1:0] c_re,
  input  logic signed [DATA_W-1:0] c_im,
  output logic                     escape
);
  localparam int PW = 2 * DATA_W;
  localparam logic [PW:0] THR = (PW + 1)'(escape_thresh(FRAC_BITS));
  logic signed [DATA_W-1:0] z_re, z_im, nr, ni;
  logic signed [PW-1:0] wr, wi, zr2, zi2, zri;
  logic [PW:0] mag;
  always_comb begin
    wr = PW'(z_re);
    wi = PW'(z_im);
    zr2 = wr * wr;
    zi2 = wi * wi;
    zri = wr * wi;
    mag = {zr2[PW-1], zr2} + {zi2[PW-1], zi2};
    escape = mag > THR;
    nr = DATA_W'((zr2 - zi2) >>> FRAC_BITS) + c_re;
    ni = DATA_W'((zri <<< 1) >>> FRAC_BITS) + c_im;
  end
  always_ff @(posedge clk)
    if (load) begin
      z_re <= z0_re;
      z_im <= z0_im;
    end else if (step) begin
      z_re <= nr;
      z_im <= ni;
    end
endmodule

// File: rtl/mandel_stream_gen.sv
// mandel_stream_gen: raster-order escape-time pixel source on AXI4-Stream.
// Julia-set mode is added when MANDEL_JULIA_EN is defined.
module mandel_stream_gen
  import mandel_pkg::*;
#(
  parameter int X_SIZE    = 640,
  parameter int Y_SIZE    = 480,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ITER_W    = ITER_W_DEF
) (
  input  logic                     out_stream_aclk,
  input  logic                     periph_resetn,
  input  logic signed [DATA_W-1:0] cfg_re_min,
  input  logic signed [DATA_W-1:0] cfg_im_max,
  input  logic signed [DATA_W-1:0] cfg_step_re,
  input  logic signed [DATA_W-1:0] cfg_step_im,
  input  logic [ITER_W-1:0]        cfg_max_iter,
`ifdef MANDEL_JULIA_EN
  input  logic                     cfg_julia,
  input  logic signed [DATA_W-1:0] cfg_c_re,
  input  logic signed [DATA_W-1:0] cfg_c_im,
`endif
  output logic [31:0]              out_stream_tdata,
  output logic [3:0]               out_stream_tkeep,
  output logic                     out_stream_tlast,
  output logic                     out_stream_tuser,
  output logic                     out_stream_tvalid,
  input  logic                     out_stream_tready
);
  localparam int XW = X_SIZE > 1 ? $clog2(X_SIZE) : 1;
  localparam int YW = Y_SIZE > 1 ? $clog2(Y_SIZE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);
  state_t state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [ITER_W-1:0] n, max_iter;
  logic signed [DATA_W-1:0] re_min, step_re, step_im, p_re, p_im, c_re, c_im, z0_re, z0_im;
  logic first, escape, done;
  assign out_stream_tkeep = 4'hF;
  assign first = x == '0 && y == '0;
  assign done = escape || n == max_iter;
`ifdef MANDEL_JULIA_EN
  logic julia, julia_now;
  logic signed [DATA_W-1:0] jc_re, jc_im;
  // at frame start the shadows are being loaded this cycle, so z0 comes straight from cfg
  assign julia_now = first ? cfg_julia : julia;
  assign c_re = julia ? jc_re : p_re;
  assign c_im = julia ? jc_im : p_im;
  assign z0_re = julia_now ? (first ? cfg_re_min : p_re) : '0;
  assign z0_im = julia_now ? (first ? cfg_im_max : p_im) : '0;
`else
  assign c_re = p_re;
  assign c_im = p_im;
  assign z0_re = '0;
  assign z0_im = '0;
`endif
  mandel_iter_core #(.DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS)) u_core (
    .clk   (out_stream_aclk),
    .load  (state == INIT),
    .step  (state == ITER && !done),
    .z0_re (z0_re),
    .z0_im (z0_im),
    .c_re  (c_re),
    .c_im  (c_im),
    .escape(escape)
  );
  always_ff @(posedge out_stream_aclk)
    if (!periph_resetn) begin
      state <= INIT;
      x <= '0;
      y <= '0;
      out_stream_tvalid <= 1'b0;
      out_stream_tdata <= '0;
      out_stream_tlast <= 1'b0;
      out_stream_tuser <= 1'b0;
    end else
      case (state)
        INIT: begin
          if (first) begin
            re_min <= cfg_re_min;
            step_re <= cfg_step_re;
            step_im <= cfg_step_im;
            max_iter <= cfg_max_iter;
            p_re <= cfg_re_min;
            p_im <= cfg_im_max;
`ifdef MANDEL_JULIA_EN
            julia <= cfg_julia;
            jc_re <= cfg_c_re;
            jc_im <= cfg_c_im;
`endif
          end
          n <= '0;
          state <= ITER;
        end
        ITER:
          if (done) begin
            out_stream_tvalid <= 1'b1;
            out_stream_tdata <= {8'h00, colour(8'(n), n == max_iter)};
            out_stream_tlast <= x == X_LAST;
            out_stream_tuser <= first;
            state <= OUT;
          end else
            n <= n + 1'b1;
        OUT:
          if (out_stream_tready) begin
            out_stream_tvalid <= 1'b0;
            state <= INIT;
            if (x == X_LAST) begin
              x <= '0;
              y <= y == Y_LAST ? '0 : y + 1'b1;
              p_re <= re_min;
              p_im <= p_im - step_im;
            end else begin
              x <= x + 1'b1;
              p_re <= p_re + step_re;
            end
          end
        default: state <= INIT;
      endcase
endmodule

// File: tb/tb_mandel_stream_gen.sv
// tb_mandel_stream_gen: directed and randomized frames on an 8x4 generator, checked
// against a plain-arithmetic escape-time model with random sink back-pressure.
module tb_mandel_stream_gen;
  localparam int NX = 8;
  localparam int NY = 4;
  localparam int NP = NX * NY;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic tready = 1'b0;
  logic signed [31:0] cfg_re_min = '0, cfg_im_max = '0, cfg_step_re = '0, cfg_step_im = '0;
  logic [7:0] cfg_max_iter = '0;
  logic [31:0] tdata;
  logic [3:0] tkeep;
  logic tlast, tuser, tvalid;
  int checks = 0;
  int failures = 0;
  int e_re, e_im, e_sr, e_si, e_mx;
  logic [31:0] fbuf [NP];
  bit after_hs = 1'b0;

  always #5 clk = ~clk;

  mandel_stream_gen #(.X_SIZE(NX), .Y_SIZE(NY)) dut (
    .out_stream_aclk  (clk),
    .periph_resetn    (rstn),
    .cfg_re_min       (cfg_re_min),
    .cfg_im_max       (cfg_im_max),
    .cfg_step_re      (cfg_step_re),
    .cfg_step_im      (cfg_step_im),
    .cfg_max_iter     (cfg_max_iter),
    .out_stream_tdata (tdata),
    .out_stream_tkeep (tkeep),
    .out_stream_tlast (tlast),
    .out_stream_tuser (tuser),
    .out_stream_tvalid(tvalid),
    .out_stream_tready(tready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // escape-time count for one point, straight from the fixed-point recurrence
  function automatic int ref_iter(input int cr, input int ci, input int mx);
    int zr, zi;
    longint a, b, p;
    logic signed [127:0] m;
    zr = 0;
    zi = 0;
    for (int n = 0; n < mx; n++) begin
      a = longint'(zr) * longint'(zr);
      b = longint'(zi) * longint'(zi);
      p = longint'(zr) * longint'(zi);
      m = 128'(a) + 128'(b);
      if (m > (128'sd4 <<< 48)) return n;
      zr = int'((a - b) >>> 24) + cr;
      zi = int'((p * 2) >>> 24) + ci;
    end
    return mx;
  endfunction

  function automatic logic [31:0] pix(input int n, input int mx);
    logic [7:0] r, g, b;
    r = 8'((n % 32) * 8);
    g = 8'((n % 64) * 4);
    b = 8'(n % 256);
    return n == mx ? 32'h0 : {8'h00, r, g, b};
  endfunction

  task automatic set_cfg(input int re, input int im, input int sr, input int si, input int mx);
    cfg_re_min = re; cfg_im_max = im; cfg_step_re = sr; cfg_step_im = si; cfg_max_iter = 8'(mx);
    e_re = re; e_im = im; e_sr = sr; e_si = si; e_mx = mx;
  endtask

  task automatic finish_now();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic get_beat(output logic [31:0] d, output logic l, output logic u, output int lat);
    int cnt = 0;
    tready = 1'b0;
    while (tvalid !== 1'b1 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    if (tvalid !== 1'b1) begin
      chk("beat_timeout", 64'(tvalid), 64'd1);
      finish_now();
    end
    d = tdata; l = tlast; u = tuser; lat = cnt;
    chk("tkeep", 64'(tkeep), 64'hF);
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      chk("stall_tvalid", 64'(tvalid), 64'd1);
      chk("stall_tdata", 64'(tdata), 64'(d));
      chk("stall_tlast", 64'(tlast), 64'(l));
      chk("stall_tuser", 64'(tuser), 64'(u));
    end
    tready = 1'b1;
    @(negedge clk);
    tready = 1'b0;
    chk("drop_tvalid", 64'(tvalid), 64'd0);
    after_hs = 1'b1;
  endtask

  task automatic run_beats(input int first, input int count, input bit cmp_prev);
    logic [31:0] d;
    logic l, u;
    int lat, px, py, n;
    bit hs;
    for (int k = first; k < first + count; k++) begin
      px = k % NX;
      py = k / NX;
      n = ref_iter(e_re + px * e_sr, e_im - py * e_si, e_mx);
      hs = after_hs;
      get_beat(d, l, u, lat);
      chk("tdata", 64'(d), 64'(pix(n, e_mx)));
      chk("tlast", 64'(l), 64'(px == NX - 1));
      chk("tuser", 64'(u), 64'(k == 0));
      if (hs) chk("latency", 64'(lat), 64'(n + 2));
      if (cmp_prev) chk("frame_repeat", 64'(d), 64'(fbuf[k]));
      fbuf[k] = d;
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_tuser", 64'(tuser), 64'd0);
    chk("rst_tkeep", 64'(tkeep), 64'hF);
  endtask

  initial begin
    int cnt;
    set_cfg(32'hFD000000, 32'h01800000, 32'h00800000, 32'h00C00000, 100);
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rstn = 1'b1;
    after_hs = 1'b0;
    run_beats(0, NP, 1'b0);
    chk("first_pixel", 64'(fbuf[0]), 64'h00080401);
    run_beats(0, NP, 1'b1);
    set_cfg(32'h02000000, 0, 0, 0, 100);
    run_beats(0, NP, 1'b0);
    chk("c_two", 64'(fbuf[5]), 64'h00100802);
    set_cfg(0, 0, 0, 0, 100);
    run_beats(0, NP, 1'b0);
    chk("c_zero", 64'(fbuf[NP-1]), 64'h0);
    set_cfg(0, 0, 0, 0, 0);
    run_beats(0, NP, 1'b0);
    for (int r = 0; r < 2; r++) begin
      set_cfg(int'(32'hFD800000) + int'($urandom_range(0, 32'h01000000)),
              int'($urandom_range(0, 32'h01400000)),
              int'($urandom_range(0, 32'h00600000)),
              int'($urandom_range(0, 32'h00A00000)),
              int'($urandom_range(1, 60)));
      run_beats(0, NP, 1'b0);
    end
    set_cfg(32'hFD000000, 32'h01800000, 32'h00800000, 32'h00C00000, 100);
    run_beats(0, 10, 1'b0);
    cfg_re_min = 32'hFE800000;
    run_beats(10, NP - 10, 1'b0);
    e_re = 32'hFE800000;
    run_beats(0, NP, 1'b0);
    run_beats(0, 5, 1'b0);
    cnt = 0;
    while (tvalid !== 1'b1 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    chk("stalled_valid", 64'(tvalid), 64'd1);
    rstn = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    rstn = 1'b1;
    after_hs = 1'b0;
    run_beats(0, NP, 1'b0);
    finish_now();
  end
endmodule

// File: doc/mandel_stream_gen.md
Name: mandel_stream_gen

Overview:
- Parametrised fixed-point Mandelbrot pixel source. Successor to the real-valued, fixed-viewport generator.
- Computes one escape-time iteration per clock and emits one 32-bit RGB pixel per AXI4-Stream beat, in raster order.
- Viewport, step size and iteration limit are run-time inputs, latched once per frame.
- Sits between the AXI-Lite register file (which drives the cfg_* ports) and the video DMA/VDMA stream input.

Parameters:
- X_SIZE, 640, pixels per line.
- Y_SIZE, 480, lines per frame.
- DATA_W, 32, signed fixed-point word width for c and z.
- FRAC_BITS, 24, fraction bits (default format Q8.24).
- ITER_W, 8, width of the iteration counter and of cfg_max_iter.

Ports:
- out_stream_aclk  in  1  sole clock.
- periph_resetn  in  1  synchronous, active-low reset.
- cfg_re_min  in  DATA_W  signed real part of the left column.
- cfg_im_max  in  DATA_W  signed imaginary part of the top row.
- cfg_step_re  in  DATA_W  signed real increment per pixel.
- cfg_step_im  in  DATA_W  signed imaginary decrement per line.
- cfg_max_iter  in  ITER_W  iteration limit.
- out_stream_tdata  out  32  pixel {8'h00,R,G,B}.
- out_stream_tkeep  out  4  constant 4'hF.
- out_stream_tlast  out  1  last pixel of each line.
- out_stream_tuser  out  1  first pixel of the frame.
- out_stream_tvalid  out  1  beat valid.
- out_stream_tready  in  1  sink ready.

Behaviour:
- Reset: one clock out_stream_aclk; synchronous active-low reset periph_resetn.
  - While periph_resetn=0 at a clock edge: state=INIT, x=y=0, tvalid=0, tdata=0, tlast=0, tuser=0; tkeep=4'hF always.
  - Reset mid-frame aborts the current pixel; the next beat after release is pixel (0,0) with tuser=1.
- FSM states: INIT -> ITER -> OUT -> INIT.
- INIT (1 cycle):
  - If x=y=0, latch all cfg_* into shadow registers. cfg changes mid-frame have no effect until the next frame.
  - Set c_re = re_min + x*step_re and c_im = im_max - y*step_im. These are formed incrementally: c_re += step_re per pixel, reloaded at line start; c_im -= step_im per line. Arithmetic is two's-complement wrap mod 2^DATA_W.
  - Set z=0, n=0.
- ITER (1 cycle per iteration):
  - Compute zr2=zr*zr, zi2=zi*zi, zri=zr*zi at 2*DATA_W.
  - mag = zr2+zi2 at 2*DATA_W+1; escape iff mag > (4 << 2*FRAC_BITS).
  - If escape, or n == max_iter: go to OUT.
  - Else:
    - zr' = ((zr2-zi2)>>>FRAC_BITS) + c_re
    - zi' = ((zri<<1)>>>FRAC_BITS) + c_im
    - Both truncated to DATA_W (arithmetic shift = floor), wrap on overflow; n++.
  - max_iter=0 goes straight to OUT with n=0.
- Colour:
  - If n == max_iter (in set): R=G=B=0.
  - Else: R={n[4:0],3'b0}, G={n[5:0],2'b0}, B=n[7:0] (bits above ITER_W read as 0).
- OUT:
  - tvalid=1; tdata/tlast/tuser are registered on entry and held stable while tvalid & !tready.
  - tlast = (x==X_SIZE-1); tuser = (x==0 && y==0).
  - On tvalid & tready: tvalid=0 on the next edge; advance x (wrap to 0 at X_SIZE-1, then y++; y wraps at Y_SIZE-1); go to INIT.
  - tvalid never drops without a handshake except on reset.
- Latency per pixel: 1 (INIT) + n+1 (ITER) + ≥1 (OUT) cycles. No back-to-back beats.

Optional Feature:
- Macro: MANDEL_JULIA_EN.
- Defined:
  - Adds inputs cfg_julia (1 bit) and cfg_c_re/cfg_c_im (DATA_W each), latched at frame start with the other cfg_*.
  - When cfg_julia=1: INIT sets z = pixel coordinate and c = (cfg_c_re, cfg_c_im).
  - When cfg_julia=0: behaviour is identical to the undefined build.
- Undefined: ports absent, Mandelbrot only.

Decomposition:
- Package mandel_pkg:
  - state enum {INIT, ITER, OUT}.
  - default DATA_W/FRAC_BITS/ITER_W.
  - ESCAPE_THRESH function of FRAC_BITS.
  - colour-mapping function.
- Sub-module mandel_iter_core: registered one-step datapath.
  - Inputs: z, c.
  - Outputs: z', escape.
  - Holds all multipliers, so the FSM stays in the top level.

Test Plan:
- Defaults, re_min=-3.0 (0xFD000000), im_max=1.5, step_re=4/640, step_im=3/480, max_iter=100 -> first beat has tuser=1, tlast=0; c=-3+1.5i escapes at n=1 -> tdata=0x00080401.
- Single pixel c=2+0i (re_min=2.0, step_re=0), max_iter=100 -> n=2 (|z|²=4 is not escape), tdata=0x00100802.
- c=0 (re_min=0, im_max=0, steps 0), max_iter=100 -> every pixel tdata=0x00000000 after 101 ITER cycles; max_iter=0 -> black after 1 ITER cycle.
- Full frame X_SIZE=8, Y_SIZE=4 with random tready -> 32 beats per frame; tlast on beats 8,16,24,32; tuser on beat 1 only; tdata stable while stalled; frame 2 repeats frame 1 bit-exactly.
- Change cfg_re_min mid-frame -> remaining pixels unchanged; next frame uses the new value.
- Assert periph_resetn=0 for 1 cycle while tvalid=1 and stalled -> tvalid=0 next edge; next beat is pixel (0,0) with tuser=1.
